// File: rtl/wb_present80_slave_if.sv
// Wishbone B4 classic bus bundle between the management SoC (master) and the
// PRESENT-80 register block (slave).
interface wb_present80_slave_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_present80_slave.sv
// Wishbone register front end around an iterative PRESENT-80 encryptor that
// computes one round per clock and raises a level interrupt on completion.
module wb_present80_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                       wb_clk_i,
  input  logic                       resetb,
  wb_present80_slave_if.slave        wbs,
  output logic                       irq_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} fsm_t;

  fsm_t        fsm_r;
  logic [63:0] pt_r, state_r, ct_r;
  logic [79:0] key_r, rk_r;
  logic [5:0]  round_r;
  logic        done_r, ie_r, ack_r;
  logic [31:0] dat_r;
  logic        wr_pend_r;
  logic [2:0]  wr_off_r;
  logic [31:0] wr_dat_r;
  logic [3:0]  wr_sel_r;

  logic        busy_s, hit_s, req_s, start_s;
  logic [2:0]  off_s;
  logic [31:0] rd_data_s, cur_wr_s, wr_word_s;
  logic [79:0] rk_rot_s, rk_next_s;
  logic [63:0] state_next_s;
  logic        unused_adr_s;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 16; i++) y[4*i +: 4] = sbox4(x[4*i +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = 64'h0;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                              input logic [31:0] din,
                                              input logic [3:0]  sel);
    logic [31:0] y;
    for (int b = 0; b < 4; b++) y[8*b +: 8] = sel[b] ? din[8*b +: 8] : old[8*b +: 8];
    return y;
  endfunction

  assign busy_s       = (fsm_r == ST_RUN);
  assign off_s        = wbs.wbs_adr_i[4:2];
  assign hit_s        = (wbs.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign req_s        = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit_s & ~ack_r;
  assign start_s      = wr_pend_r & (wr_off_r == 3'd5) & wr_sel_r[0] & wr_dat_r[0];
  assign unused_adr_s = ^wbs.wbs_adr_i[1:0];
  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = dat_r;
  assign irq_o        = done_r & ie_r;

  // Read mux for the addressed register
  always_comb begin
    rd_data_s = 32'h0;
    case (off_s)
      3'd0:    rd_data_s = pt_r[31:0];
      3'd1:    rd_data_s = pt_r[63:32];
      3'd2:    rd_data_s = key_r[31:0];
      3'd3:    rd_data_s = key_r[63:32];
      3'd4:    rd_data_s = {16'h0, key_r[79:64]};
      3'd5:    rd_data_s = {28'h0, ie_r, done_r, busy_s, 1'b0};
      3'd6:    rd_data_s = ct_r[31:0];
      3'd7:    rd_data_s = ct_r[63:32];
      default: rd_data_s = 32'h0;
    endcase
  end

  // Current contents of the pending write target, merged with enabled byte lanes
  always_comb begin
    cur_wr_s = 32'h0;
    case (wr_off_r)
      3'd0:    cur_wr_s = pt_r[31:0];
      3'd1:    cur_wr_s = pt_r[63:32];
      3'd2:    cur_wr_s = key_r[31:0];
      3'd3:    cur_wr_s = key_r[63:32];
      3'd4:    cur_wr_s = {16'h0, key_r[79:64]};
      default: cur_wr_s = 32'h0;
    endcase
    wr_word_s = merge_bytes(cur_wr_s, wr_dat_r, wr_sel_r);
  end

  // One PRESENT round: rotate-left-61 key schedule and sBox/pLayer on the state
  always_comb begin
    rk_rot_s           = {rk_r[18:0], rk_r[79:19]};
    rk_next_s          = rk_rot_s;
    rk_next_s[79:76]   = sbox4(rk_rot_s[79:76]);
    rk_next_s[19:15]   = rk_rot_s[19:15] ^ round_r[4:0];
    state_next_s       = p_layer(sbox_layer(state_r ^ rk_r[79:16]));
  end

  // Bus handshake, register writes and round sequencing
  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      fsm_r     <= ST_IDLE;
      pt_r      <= 64'h0;
      state_r   <= 64'h0;
      ct_r      <= 64'h0;
      key_r     <= 80'h0;
      rk_r      <= 80'h0;
      round_r   <= 6'd0;
      done_r    <= 1'b0;
      ie_r      <= 1'b0;
      ack_r     <= 1'b0;
      dat_r     <= 32'h0;
      wr_pend_r <= 1'b0;
      wr_off_r  <= 3'd0;
      wr_dat_r  <= 32'h0;
      wr_sel_r  <= 4'h0;
    end else begin
      if (req_s) begin
        ack_r     <= 1'b1;
        dat_r     <= wbs.wbs_we_i ? 32'h0 : rd_data_s;
        wr_pend_r <= wbs.wbs_we_i;
        wr_off_r  <= off_s;
        wr_dat_r  <= wbs.wbs_dat_i;
        wr_sel_r  <= wbs.wbs_sel_i;
      end else begin
        ack_r     <= 1'b0;
        dat_r     <= 32'h0;
        wr_pend_r <= 1'b0;
      end

      // Writes land at the end of the ack cycle; operands are frozen while busy
      if (wr_pend_r) begin
        case (wr_off_r)
          3'd0: if (!busy_s) pt_r[31:0]   <= wr_word_s;
          3'd1: if (!busy_s) pt_r[63:32]  <= wr_word_s;
          3'd2: if (!busy_s) key_r[31:0]  <= wr_word_s;
          3'd3: if (!busy_s) key_r[63:32] <= wr_word_s;
          3'd4: if (!busy_s) key_r[79:64] <= wr_word_s[15:0];
          3'd5: if (wr_sel_r[0]) begin
            ie_r <= wr_dat_r[3];
            if (wr_dat_r[2]) done_r <= 1'b0;
          end
          default: ;
        endcase
      end

      case (fsm_r)
        ST_IDLE: if (start_s) begin
          state_r <= pt_r;
          rk_r    <= key_r;
          round_r <= 6'd1;
          done_r  <= 1'b0;
          fsm_r   <= ST_RUN;
        end
        ST_RUN: if (round_r == 6'd32) begin
          ct_r    <= state_r ^ rk_r[79:16];
          done_r  <= 1'b1;
          round_r <= 6'd0;
          fsm_r   <= ST_IDLE;
        end else begin
          state_r <= state_next_s;
          rk_r    <= rk_next_s;
          round_r <= round_r + 6'd1;
        end
        default: fsm_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_present80_slave.sv
// Directed self-checking bench for wb_present80_slave using the PRESENT-80
// reference vectors and hand-computed register values.
module tb_wb_present80_slave;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_PT0 = BASE + 32'h00, A_PT1 = BASE + 32'h04;
  localparam logic [31:0] A_K0 = BASE + 32'h08, A_K1 = BASE + 32'h0C, A_K2 = BASE + 32'h10;
  localparam logic [31:0] A_CTRL = BASE + 32'h14, A_CT0 = BASE + 32'h18, A_CT1 = BASE + 32'h1C;
  localparam logic [63:0] CT_Z = 64'h5579C138_7B228445;
  localparam logic [79:0] K_ONES = {80{1'b1}};
  localparam logic [63:0] P_ONES = {64{1'b1}};

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic irq;
  int n_tests = 0;
  int n_fail = 0;
  int unsigned cycle = 0;

  wb_present80_slave_if bus();

  wb_present80_slave #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .resetb(resetb), .wbs(bus), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
    @(negedge clk);
    check("ack_idle", bus.wbs_ack_o, 1'b0);
    check("dat_idle", bus.wbs_dat_o, 32'h0);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = wdat; bus.wbs_sel_i = sel;
    acked = 1'b0; rdat = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        acked = 1'b1;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    logic a;
    wb_xfer(1'b1, adr, d, sel, r, a);
    check("wr_ack", a, 1'b1);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
    logic a;
    wb_xfer(1'b0, adr, 32'h0, 4'h0, d, a);
    check("rd_ack", a, 1'b1);
  endtask

  task automatic load(input logic [63:0] pt, input logic [79:0] key);
    wb_wr(A_PT0, pt[31:0], 4'hF);
    wb_wr(A_PT1, pt[63:32], 4'hF);
    wb_wr(A_K0, key[31:0], 4'hF);
    wb_wr(A_K1, key[63:32], 4'hF);
    wb_wr(A_K2, {16'h0, key[79:64]}, 4'hF);
  endtask

  task automatic read_ct(output logic [63:0] ct);
    logic [31:0] lo, hi;
    wb_rd(A_CT0, lo);
    wb_rd(A_CT1, hi);
    ct = {hi, lo};
  endtask

  task automatic encrypt(input string tag, input logic [63:0] pt, input logic [79:0] key,
                         input logic [63:0] exp_ct);
    logic [31:0] d;
    logic [63:0] ct;
    load(pt, key);
    wb_wr(A_CTRL, 32'h1, 4'h1);
    wb_rd(A_CTRL, d);
    check({tag, "_busy"}, d[2:1], 2'b01);
    for (int i = 0; i < 40; i++) begin
      wb_rd(A_CTRL, d);
      if (d[2]) break;
    end
    check({tag, "_done"}, d, 32'h4);
    read_ct(ct);
    check(tag, ct, exp_ct);
  endtask

  task automatic wait_irq(input int unsigned t0, output int unsigned len);
    for (int i = 0; i < 100; i++) begin
      if (irq) break;
      @(negedge clk);
    end
    len = cycle - t0;
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] ct;
    logic a;
    int unsigned t0, len;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_irq", irq, 1'b0);
    resetb = 1'b1;

    for (int k = 0; k < 8; k++) begin
      wb_rd(BASE + 32'(4 * k), d);
      check("rst_read", d, 32'h0);
    end

    encrypt("ct_zero", 64'h0, 80'h0, CT_Z);
    encrypt("ct_kones", 64'h0, K_ONES, 64'hE72C46C0_F5945049);
    encrypt("ct_pones", P_ONES, 80'h0, 64'hA112FFC7_2F68417B);
    encrypt("ct_both", P_ONES, K_ONES, 64'h3333DCD3_213210D2);

    wb_wr(A_PT0, 32'h0, 4'hF);
    wb_wr(A_PT0, 32'h1234ABCD, 4'b0010);
    wb_rd(A_PT0, d);
    check("byte_lane", d, 32'h0000AB00);

    wb_wr(A_K2, 32'hFFFFFFFF, 4'hF);
    wb_rd(A_K2, d);
    check("key_hi_mask", d, 32'h0000FFFF);

    // Interrupt and busy length
    load(64'h0, 80'h0);
    wb_wr(A_CTRL, 32'h9, 4'h1);
    t0 = cycle;
    wait_irq(t0, len);
    check("busy_len", len, 33);
    check("irq_high", irq, 1'b1);
    read_ct(ct);
    check("ct_irq", ct, CT_Z);
    wb_wr(A_CTRL, 32'hC, 4'h1);
    @(negedge clk);
    check("irq_clear", irq, 1'b0);
    wb_rd(A_CTRL, d);
    check("ctrl_after_clr", d, 32'h8);

    // Operand writes and restart while busy are ignored
    wb_wr(A_CTRL, 32'h9, 4'h1);
    t0 = cycle;
    wb_wr(A_PT0, 32'hDEADBEEF, 4'hF);
    wb_wr(A_CTRL, 32'h9, 4'h1);
    wait_irq(t0, len);
    check("busy_len_restart", len, 33);
    wb_rd(A_PT0, d);
    check("pt_frozen", d, 32'h0);
    read_ct(ct);
    check("ct_frozen", ct, CT_Z);

    // Reset in the middle of an encryption
    load(P_ONES, K_ONES);
    wb_wr(A_CTRL, 32'h1, 4'h1);
    repeat (10) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    check("rst_mid_irq", irq, 1'b0);
    resetb = 1'b1;
    wb_rd(A_CTRL, d);
    check("rst_mid_ctrl", d, 32'h0);
    read_ct(ct);
    check("rst_mid_ct", ct, 64'h0);
    encrypt("ct_after_rst", P_ONES, K_ONES, 64'h3333DCD3_213210D2);

    wb_xfer(1'b0, 32'h3000_0040, 32'h0, 4'h0, d, a);
    check("out_of_window", a, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wb_present80_slave.md
Name: wb_present80_slave

Overview:
- Wishbone B4 classic responder in the user project area; the management SoC is the initiator.
- Firmware writes a 64-bit plaintext and an 80-bit key through memory-mapped registers, then triggers encryption.
- An iterative PRESENT-80 datapath computes one round per clock. Firmware polls status or takes an interrupt, then reads the 64-bit ciphertext.
- This block is the responder side of the management Wishbone port that the WB port test exercises.

Parameters:
- BASE_ADDR, 32'h3000_0000, register window base; decode compares wbs_adr_i[31:5] with BASE_ADDR[31:5].

Ports:
- wb_clk_i  in  1  single clock, all state on rising edge
- resetb  in  1  reset, asynchronous, active-low
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  4  byte enables for writes
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- irq_o  out  1  level interrupt, equals done & ie

Behaviour:
- Reset (async assert, sync release): wbs_ack_o=0, wbs_dat_o=0, irq_o=0. PT, KEY, CT and state are zeroed; busy=0, done=0, ie=0, round=0.
- Request accepted when cyc & stb & address hit & !wbs_ack_o.
  - wbs_ack_o rises the next cycle for exactly one cycle.
  - wbs_dat_o is valid in the ack cycle and is 0 outside ack cycles.
  - No wait states; no err/rty.
- Requests inside the window with an unmapped offset are acked; read 0, writes dropped. Requests outside the window are never acked.
- Writes honour wbs_sel_i per byte. Reads return the full word.
- Register map (byte offsets):
  - 0x00 PT[31:0] RW; 0x04 PT[63:32] RW
  - 0x08 KEY[31:0] RW; 0x0C KEY[63:32] RW; 0x10 KEY[79:64] in bits[15:0] RW, bits[31:16] read 0
  - 0x14 CTRL:
    - bit0 START, write-1 pulse, reads 0
    - bit1 BUSY RO
    - bit2 DONE, sticky; write-1 clears
    - bit3 IE RW
  - 0x18 CT[31:0] RO; 0x1C CT[63:32] RO
- Writes to PT/KEY while busy=1 are acked and ignored. START while busy=1 is ignored.
- START accepted in the ack cycle T:
  - At T+1: state=PT, rk=KEY, round=1, busy=1, done=0.
  - If the same write also sets bit2, START wins and done is cleared.
- Each busy cycle:
  - state <= pLayer(sBox(state ^ rk[79:16]))
  - rk <= rotate-left-61, then rk[79:76]=S(rk[79:76]), then rk[19:15]^=round[4:0]
  - round increments
- After the round-31 update: CT <= state ^ rk[79:16], busy=0, done=1. Busy stays high for exactly 32 cycles. CT updates only on completion.
- S-box (hex, input 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- pLayer: bit i moves to position (16*i) mod 63 for i<63; bit 63 stays at 63.
- Reset mid-encryption aborts the operation: busy=0, done=0, CT=0.
- A CTRL read in the completion cycle returns the pre-update values; the next read shows busy=0, done=1.

Test Plan:
- Reset then read all eight offsets -> all 0; ack high exactly 1 cycle per access.
- PT=0, KEY=0, START; poll CTRL -> BUSY for 32 cycles, then DONE=1; CT hi/lo = 5579C138 / 7B228445.
- PT=0, KEY=FFFF_FFFF_FFFF_FFFF_FFFF -> CT E72C46C0_F5945049. PT=all-ones, KEY=0 -> A112FFC7_2F68417B. PT=all-ones, KEY=all-ones -> 3333DCD3_213210D2.
- Byte-lane write: sel=4'b0010, data 0x0000AB00 to 0x00 after PT=0 -> PT[31:0] reads 0x0000AB00.
  - Write PT during BUSY -> PT unchanged and CT unaffected.
  - Second START during BUSY -> busy length stays 32.
- IE=1 then encrypt -> irq_o rises with DONE; write CTRL bit2=1 -> irq_o=0.
  - Reset asserted at round 10 -> busy=0, done=0, CT=0; a fresh START completes correctly.
- Address 0x3000_0040 -> no ack. Offset 0x10 read -> bits[31:16]=0.
